// File: rtl/fir_out_requant.sv
`default_nettype none
// fir_out_requant: round-half-up + saturate a wide FIR output to OUT_W bits, then buffer it in a FIFO behind a valid/ready stream.
// Optional build macro FIR_REQUANT_SATCNT_EN adds a 16-bit saturating count of clamped samples.
module fir_out_requant #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [IN_W-1:0]               data_in,
  input  logic                          in_valid,
  output logic [OUT_W-1:0]              data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sat_flag,
  output logic                          drop_flag,
`ifdef FIR_REQUANT_SATCNT_EN
  output logic [15:0]                   sat_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = IN_W + 1;

  localparam logic signed [SW-1:0] HALF   = $signed({{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [SW-1:0] SAT_HI = $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_LO = $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic [LW-1:0]        FULL_LEVEL = LW'(FIFO_DEPTH);

  if (SHIFT < 1 || SHIFT > IN_W - OUT_W + 1) begin : g_bad_shift
    $error("fir_out_requant: SHIFT out of range");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_out_requant: FIFO_DEPTH must be a power of two >= 4");
  end

  // ---------------- stage 1: round half up, drop SHIFT fraction bits
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] s1;
  logic                 v1;

  assign ext     = $signed({data_in[IN_W-1], data_in});
  assign rounded = ext + HALF;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1 <= rounded >>> SHIFT;
      end
    end
  end

  // ---------------- stage 2: clamp on the full-width shifted value
  logic                 over_hi;
  logic                 over_lo;
  logic                 clamp;
  logic [OUT_W-1:0]     clamped;
  logic [OUT_W-1:0]     q2;
  logic                 v2;

  always_comb begin
    over_hi = (s1 > SAT_HI);
    over_lo = (s1 < SAT_LO);
    clamp   = over_hi || over_lo;
    if (over_hi) begin
      clamped = SAT_HI[OUT_W-1:0];
    end else if (over_lo) begin
      clamped = SAT_LO[OUT_W-1:0];
    end else begin
      clamped = s1[OUT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      v2       <= 1'b0;
      q2       <= '0;
      sat_flag <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        q2 <= clamped;
      end
      if (v1 && clamp) begin
        sat_flag <= 1'b1;
      end
    end
  end

`ifdef FIR_REQUANT_SATCNT_EN
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (v1 && clamp && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

  // ---------------- output FIFO with registered head
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    held_cnt;
  logic [LW-1:0]    level_next;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  always_comb begin
    pop        = out_valid && out_ready;
    full       = (fifo_level == FULL_LEVEL);
    push       = v2 && (!full || pop);
    drop       = v2 && full && !pop;
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    held_cnt   = pop ? fifo_level - LW'(1) : fifo_level;
    level_next = push ? held_cnt + LW'(1) : held_cnt;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= q2;
    end
  end

  // The head is presented only from entries already stored before this edge,
  // so a freshly written sample never falls straight through to data_out.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      drop_flag  <= 1'b0;
    end else begin
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
      out_valid  <= (held_cnt != '0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (held_cnt != '0) begin
        data_out <= mem[rd_next];
      end
      if (drop) begin
        drop_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant.sv
`default_nettype none
// tb_fir_out_requant: table vectors, hand-written corner sequences and random traffic against a queue-based model.
module tb_fir_out_requant;

  localparam int IN_W       = 32;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 15;
  localparam int FIFO_DEPTH = 8;

  localparam longint SCALE = longint'(1) << SHIFT;
  localparam longint HALFV = longint'(1) << (SHIFT - 1);
  localparam longint MAXV  = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MINV  = -(longint'(1) << (OUT_W - 1));

  logic                 CLK = 1'b0;
  logic                 reset;
  logic [IN_W-1:0]      data_in;
  logic                 in_valid;
  logic [OUT_W-1:0]     data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sat_flag;
  logic                 drop_flag;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0]          sat_count;
`endif

  always #5 CLK = ~CLK;

  fir_out_requant #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .data_in(data_in),
    .in_valid(in_valid),
    .data_out(data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag(sat_flag),
    .drop_flag(drop_flag),
`ifdef FIR_REQUANT_SATCNT_EN
    .sat_count(sat_count),
`endif
    .fifo_level(fifo_level)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: samples become FIFO entries two edges after capture and
  // are presentable only from the edge after they were stored.
  typedef struct { logic [15:0] val; bit sat; int wedge; } pend_t;
  typedef struct { logic [15:0] val; int w; } ent_t;
  pend_t pend[$];
  ent_t  mq[$];
  bit    m_sat;
  bit    m_drop;
  int    cyc = 0;

  logic        p_valid = 1'b0;
  logic [15:0] p_data  = '0;
  logic [15:0] got[$];

  typedef struct { logic [31:0] din; logic [15:0] exp; bit sat_after; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] requant(input logic [31:0] d, output bit s);
    longint v, qv;
    v  = longint'($signed(d)) + HALFV;
    qv = v / SCALE;
    if (v < 0 && (v % SCALE) != 0) qv = qv - 1;
    s = 1'b0;
    if (qv > MAXV) begin s = 1'b1; qv = MAXV; end
    else if (qv < MINV) begin s = 1'b1; qv = MINV; end
    return 16'(qv);
  endfunction

  task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy, input bit rn);
    int    e;
    bit    mvalid;
    bit    s;
    pend_t p;
    ent_t  en;
    if (rn && p_valid && ordy) got.push_back(p_data);
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    reset     = rn;
    e = cyc + 1;
    if (!rn) begin
      mq.delete();
      pend.delete();
      m_sat  = 1'b0;
      m_drop = 1'b0;
    end else begin
      mvalid = (mq.size() > 0) && (mq[0].w < cyc);
      if (mvalid && ordy) void'(mq.pop_front());
      foreach (pend[i]) if (pend[i].wedge - 1 == e && pend[i].sat) m_sat = 1'b1;
      if (pend.size() > 0 && pend[0].wedge == e) begin
        if (mq.size() < FIFO_DEPTH) begin
          en.val = pend[0].val;
          en.w   = e;
          mq.push_back(en);
        end else begin
          m_drop = 1'b1;
        end
        void'(pend.pop_front());
      end
      if (iv) begin
        p.val   = requant(d, s);
        p.sat   = s;
        p.wedge = e + 2;
        pend.push_back(p);
      end
    end
    @(posedge CLK);
    cyc = e;
    #1;
    mvalid = (mq.size() > 0) && (mq[0].w < cyc);
    chk("out_valid", 32'(out_valid), 32'(mvalid));
    if (mvalid) chk("data_out", 32'(data_out), 32'(mq[0].val));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    chk("drop_flag", 32'(drop_flag), 32'(m_drop));
    if (rn && p_valid && !ordy) chk("hold_data", 32'(data_out), 32'(p_data));
    p_valid = out_valid;
    p_data  = data_out;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, ordy, 1'b1);
  endtask

  task automatic check_got(input string nm, input int n);
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk(nm, 32'(got[i]), 32'(i + 1));
  endtask

  initial begin
    int sent;
    int tmp;
    bit iv;
    logic [31:0] d;

    tbl[0] = '{32'h0000_4000, 16'd1,      1'b0};
    tbl[1] = '{32'h0000_3FFF, 16'd0,      1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 16'd0,      1'b0};
    tbl[3] = '{32'hFFFF_C000, 16'd0,      1'b0};
    tbl[4] = '{32'h3FFF_8000, 16'h7FFF,   1'b0};
    tbl[5] = '{32'h4000_0000, 16'h7FFF,   1'b1};
    tbl[6] = '{32'hC000_0000, 16'h8000,   1'b1};
    tbl[7] = '{32'h8000_0000, 16'h8000,   1'b1};

    in_valid = 1'b0; data_in = '0; out_ready = 1'b0; reset = 1'b0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("reset_data_out", 32'(data_out), 32'd0);

    // rounding and saturation table, exact 3-cycle latency
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].din, 1'b1, 1'b1);
      idle(2, 1'b1);
      chk("lat2_not_valid", 32'(out_valid), 32'd0);
      idle(1, 1'b1);
      chk("lat3_valid", 32'(out_valid), 32'd1);
      chk("tbl_value", 32'(data_out), 32'(tbl[i].exp));
      chk("tbl_sat_flag", 32'(sat_flag), 32'(tbl[i].sat_after));
      idle(1, 1'b1);
    end
`ifdef FIR_REQUANT_SATCNT_EN
    chk("sat_count", 32'(sat_count), 32'd2);
`endif

    // fill past full with no consumer: 9 and 10 are dropped
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) cycle(1'b1, 32'(k) << 15, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    chk("full_drop", 32'(drop_flag), 32'd1);
    got.delete();
    idle(20, 1'b1);
    check_got("drain_order", 8);

    // push and pop together while full
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    got.delete();
    for (int k = 0; k < 26; k++) begin
      cycle(1'b1, 32'(k + 1) << 15, k >= 10, 1'b1);
      if (k >= 10) begin
        chk("pushpop_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        chk("pushpop_drop", 32'(drop_flag), 32'd0);
      end
    end
    idle(20, 1'b1);
    check_got("pushpop_order", 26);

    // backpressure toggling on a ramp 0..31
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    got.delete();
    sent = 0;
    for (int k = 0; k < 130; k++) begin
      iv = (k % 3 == 0) && (sent < 32);
      cycle(iv, 32'(sent) << 15, k[0], 1'b1);
      if (iv) sent++;
    end
    chk("ramp_count", 32'(got.size()), 32'd32);
    for (int i = 0; i < 32 && i < got.size(); i++) chk("ramp_order", 32'(got[i]), 32'(i));

    // reset with 5 buffered and 2 in flight
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b1, (k == 0) ? 32'h4000_0000 : (32'(k + 1) << 15), 1'b0, 1'b1);
    chk("pre_reset_level", 32'(fifo_level), 32'd5);
    chk("pre_reset_sat", 32'(sat_flag), 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_level", 32'(fifo_level), 32'd0);
    chk("mid_reset_sat", 32'(sat_flag), 32'd0);
    chk("mid_reset_drop", 32'(drop_flag), 32'd0);
    chk("mid_reset_data", 32'(data_out), 32'd0);
    cycle(1'b1, 32'd7 << 15, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("post_reset_lat2", 32'(out_valid), 32'd0);
    idle(1, 1'b1);
    chk("post_reset_lat3", 32'(out_valid), 32'd1);
    chk("post_reset_data", 32'(data_out), 32'd7);
    idle(4, 1'b1);

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 255)) << 14;
        default: begin
          tmp = int'($urandom_range(0, 33554432)) - 16777216;
          d = 32'(tmp);
        end
      endcase
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6, $urandom_range(0, 399) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Output-side companion to FIR_filter.
- Takes the free-running signed 32-bit filter output and requantizes it to signed 16-bit, using round-half-up and saturation.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the downstream consumer (DAC formatter or capture logic).
- Restores the sample width that was fed into the filter.

Parameters:
- IN_W, 32, input sample width (two's complement).
- OUT_W, 16, output sample width (two's complement).
- SHIFT, 15, right-shift (fraction bits dropped); range 1..IN_W-OUT_W+1.
- FIFO_DEPTH, 8, output FIFO entries; power of two, min 4.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in  input  IN_W  signed filter output sample.
- in_valid  input  1  data_in is a new sample this cycle.
- data_out  output  OUT_W  signed requantized sample, FIFO head.
- out_valid  output  1  data_out holds a valid sample.
- out_ready  input  1  consumer accepts data_out this cycle.
- sat_flag  output  1  sticky: at least one sample saturated.
- drop_flag  output  1  sticky: at least one sample lost to FIFO full.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at posedge): pipeline valids, FIFO pointers, fifo_level, sat_flag and drop_flag clear to 0. data_out=0 and out_valid=0 on the following cycle. Reset mid-stream discards all in-flight and buffered samples.
- No upstream backpressure; the filter is free-running.
- Stage 1 (registered): when in_valid, sum = sign-extend(data_in, IN_W+1) + 2^(SHIFT-1), then arithmetic right shift by SHIFT. v1 <= in_valid.
- Stage 2 (registered): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Clamping is determined from the full shifted value, never by truncation. v2 <= v1. On clamp with v1=1, set sat_flag.
- FIFO write: when v2=1 and FIFO not full, write the stage-2 value. When v2=1 and FIFO full, discard the sample and set drop_flag; FIFO contents are unchanged.
- Latency: sample with in_valid at edge N is written at edge N+2, and is visible as data_out/out_valid after edge N+3 if the FIFO was empty. Fall-through bypass is not permitted.
- FIFO read: pop on out_valid && out_ready. data_out is stable while out_valid && !out_ready.
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds with no drop. Occupancy stays FIFO_DEPTH.
- Simultaneous push and pop when empty: the push lands, and out_valid rises the next cycle.
- fifo_level counts 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- sat_flag and drop_flag clear only on reset.

Optional Feature:
- Macro: FIR_REQUANT_SATCNT_EN.
- Defined: adds output port sat_count, 16 bits, unsigned.
  - Increments once per clamped sample.
  - Saturates at 0xFFFF with no wrap.
  - Clears on reset.
- Undefined: port and counter are absent. sat_flag behaviour is identical in both builds.

Test Plan:
- Rounding, defaults, out_ready=1:
  - data_in 0x00004000 -> 1.
  - data_in 0x00003FFF -> 0.
  - data_in 0xFFFFFFFF -> 0.
  - data_in 0xFFFFC000 -> 0 (half rounds up).
  - Each sample appears exactly 3 cycles after its in_valid edge.
- Saturation:
  - 0x3FFF8000 -> 32767, sat_flag stays 0.
  - 0x40000000 -> 32767, sat_flag 1.
  - 0xC0000000 -> -32768, no saturation.
  - 0x80000000 -> -32768.
  - With FIR_REQUANT_SATCNT_EN, sat_count=2 after the sequence.
- Full/drop: out_ready=0, push 10 consecutive samples 1..10 (as 1<<15 multiples) -> fifo_level=8, drop_flag=1. Then out_ready=1 -> outputs 1..8 in order, samples 9 and 10 absent.
- Push+pop at full: fill to 8, then out_ready=1 with in_valid continuous -> fifo_level holds 8, drop_flag stays 0, order preserved.
- Backpressure stability: toggle out_ready every other cycle on ramp 0..31 -> data_out never changes while out_valid && !out_ready, and all 32 values arrive in order.
- Reset mid-stream: assert reset low for one cycle with 5 samples buffered and 2 in flight -> next cycle out_valid=0, fifo_level=0, both flags 0. The first post-reset sample appears 3 cycles after its in_valid.
